transpose_seq_ctrl: RTL and testbench
=====================================

Name: transpose_seq_ctrl

Overview:
Sequencing controller for one SYSTOLIC_WIDTH x SYSTOLIC_WIDTH transposition register array.
- Array registers shift every cycle and have no enable. This block buffers a full block of input vectors, then drives the array with exactly N load cycles followed by exactly N drain cycles.
- Drained rows are captured into an output buffer.
- Presents valid/ready streams on both sides, so upstream and downstream stalls never corrupt array contents.

Parameters:
DATA_WIDTH, 16, element width in bits
SYSTOLIC_WIDTH, 4, array dimension N; block = N vectors of N lanes

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input vector valid
in_ready  out  1  input vector accepted when in_valid & in_ready
in_data  in  N*DATA_WIDTH  input vector; lane i = bits [(i+1)*DW-1 : i*DW]
cfg_dir  in  1  drain direction, sampled on block start (0 top-first, 1 bottom-first)
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  N*DATA_WIDTH  transposed output vector, same lane packing
busy  out  1  high in LOAD or DRAIN
arr_mode  out  1  to array: 0 = load (horizontal), 1 = drain (vertical)
arr_dir  out  1  to array vertical direction
arr_in  out  N*DATA_WIDTH  to array column input
arr_out  in  N*DATA_WIDTH  from array output row (reg[r][0] at MSB lane)

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, arr_mode=0, arr_dir=0, arr_in=0. All counters are 0 and the state is IDLE.
- Storage:
  - Input stage: N-entry buffer written at in_cnt (0..N).
  - Output stage: N-entry FIFO with rd_ptr/wr_ptr and out_cnt (0..N).
- in_ready = (state==IDLE) && (in_cnt<N). Each accepted vector is written to entry in_cnt, then in_cnt increments.
- IDLE -> LOAD when in_cnt==N and out_cnt==0. This guarantees the FIFO can absorb all N drained rows. Latch cfg_dir into arr_dir on this transition; arr_dir is held constant until the next block start.
- LOAD: step counter k = 0..N-1. arr_mode=0 and arr_in = staged entry k, both registered so the array sees them on consecutive cycles. After N cycles go to DRAIN with no gap, because the array cannot hold its contents.
- DRAIN: step counter k = 0..N-1. arr_mode=1. On each DRAIN cycle push arr_out, with lanes reversed, into the FIFO. Reversal means array reg[r][0] goes to out lane 0.
  - For a block v0..v(N-1): out vector k lane m = v_m lane k when dir=0, and v_m lane (N-1-k) when dir=1.
  - After N cycles go to IDLE and clear in_cnt.
- Outside LOAD: arr_in=0. arr_mode=0 in IDLE; array contents are don't-care there.
- Output side:
  - out_valid = (out_cnt>0); out_data = FIFO head, registered or read-combinationally from storage.
  - A push during DRAIN and a pop on the same cycle are legal: out_cnt is unchanged and the pointers wrap modulo N.
- The next block may be collected in IDLE while the FIFO is still draining. Its LOAD waits for out_cnt==0.
- Reset mid-operation: all state and counters clear immediately. A partially loaded or partially drained block is discarded.
- in_valid while in_ready=0 is held by upstream per the handshake; the block does not sample it. cfg_dir changes outside block start have no effect.

Optional Feature:
TRANSPOSE_SEQ_CTRL_PERF_CNT_EN
- When defined: adds output perf_blocks (32 bits, reset 0), incremented once per completed DRAIN; and output perf_stall (32 bits, reset 0), incremented each IDLE cycle with in_cnt==N and out_cnt!=0. Both counters wrap at 2^32.
- When undefined: neither port nor either counter exists.

Test Plan:
1. N=4, dir=0: push v_k lane i = 16'h00(k)(i), e.g. v1 = {0013,0012,0011,0010}, with out_ready=1. Required: out0 = {0030,0020,0010,0000}, out1 = {0031,0021,0011,0001}, through out3; busy high for exactly 8 cycles.
2. Same data with dir=1: out0 = {0033,0023,0013,0003}, out3 = {0030,0020,0010,0000}; arr_dir=1 throughout LOAD and DRAIN.
3. Random in_valid gaps (≈50%) and random out_ready: output values are identical to scenario 1; arr_mode still shows unbroken 4x0 then 4x1 runs.
4. Back-to-back blocks with out_ready=0 after block 1: block 2 is collected (in_ready drops at in_cnt=4), LOAD is held off until all 4 outputs pop, then block 2 transposes correctly.
5. Assert rst_n low during DRAIN cycle 2: all outputs return to reset values; a fresh block afterwards yields correct results with no stale rows.
6. With TRANSPOSE_SEQ_CTRL_PERF_CNT_EN: after scenario 4, perf_blocks=2 and perf_stall equals the counted hold-off cycles.

Source files
------------

// File: rtl/transpose_seq_ctrl.sv
// Sequencer for an NxN shift-only transposition array: stage N vectors, run N load + N drain cycles, buffer rows.
// Optional perf counters (perf_blocks, perf_stall) are built in when TRANSPOSE_SEQ_CTRL_PERF_CNT_EN is defined.
module transpose_seq_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int SYSTOLIC_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                                 cfg_dir,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_data,
  output logic                                 busy,
  output logic                                 arr_mode,
  output logic                                 arr_dir,
  output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_in,
  input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_out
`ifdef TRANSPOSE_SEQ_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                          perf_blocks,
  output logic [31:0]                          perf_stall
`endif
);

  localparam int N  = SYSTOLIC_WIDTH;
  localparam int VW = N * DATA_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  state_t        r_state;
  logic [PW-1:0] r_k;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_in_cnt;
  logic [CW-1:0] r_out_cnt;
  logic [VW-1:0] r_in_buf [N];
  logic [VW-1:0] r_fifo   [N];
  logic          r_arr_mode;
  logic          r_arr_dir;
  logic [VW-1:0] r_arr_in;

  logic          w_in_fire;
  logic          w_start;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_k_next;
  logic [PW-1:0] w_rd_next;
  logic [PW-1:0] w_wr_next;
  logic [VW-1:0] w_rev;

  assign in_ready  = (r_state == S_IDLE) && (r_in_cnt < CNT_FULL);
  assign w_in_fire = in_valid && in_ready;
  // Only start once the FIFO is empty so all N drained rows are guaranteed a slot.
  assign w_start   = (r_state == S_IDLE) && (r_in_cnt == CNT_FULL) && (r_out_cnt == '0);
  assign w_push    = (r_state == S_DRAIN);
  assign out_valid = (r_out_cnt != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? r_fifo[r_rd_ptr] : '0;

  assign w_k_next  = (r_k      == IDX_LAST) ? '0 : r_k      + PW'(1);
  assign w_rd_next = (r_rd_ptr == IDX_LAST) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_next = (r_wr_ptr == IDX_LAST) ? '0 : r_wr_ptr + PW'(1);

  assign busy     = (r_state != S_IDLE);
  assign arr_mode = r_arr_mode;
  assign arr_dir  = r_arr_dir;
  assign arr_in   = r_arr_in;

  // The array presents reg[r][0] in the top lane; flip so it lands in output lane 0.
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < N; i++) begin
      w_rev[i*DATA_WIDTH +: DATA_WIDTH] = arr_out[(N-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_arr_mode <= 1'b0;
      r_arr_dir  <= 1'b0;
      r_arr_in   <= '0;
      for (int i = 0; i < N; i++) begin
        r_in_buf[i] <= '0;
        r_fifo[i]   <= '0;
      end
    end else begin
      if (w_in_fire) begin
        r_in_buf[r_in_cnt[PW-1:0]] <= in_data;
        r_in_cnt                   <= r_in_cnt + CW'(1);
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_rev;
        r_wr_ptr         <= w_wr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_push && !w_pop) begin
        r_out_cnt <= r_out_cnt + CW'(1);
      end else if (!w_push && w_pop) begin
        r_out_cnt <= r_out_cnt - CW'(1);
      end

      // arr_mode/arr_in are registered alongside the state so the array sees them one cycle later, back-to-back.
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_LOAD;
            r_k        <= '0;
            r_arr_dir  <= cfg_dir;
            r_arr_mode <= 1'b0;
            r_arr_in   <= r_in_buf[0];
          end
        end
        S_LOAD: begin
          if (r_k == IDX_LAST) begin
            r_state    <= S_DRAIN;
            r_k        <= '0;
            r_arr_mode <= 1'b1;
            r_arr_in   <= '0;
          end else begin
            r_k      <= w_k_next;
            r_arr_in <= r_in_buf[w_k_next];
          end
        end
        S_DRAIN: begin
          if (r_k == IDX_LAST) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_arr_mode <= 1'b0;
            r_in_cnt   <= '0;
          end else begin
            r_k <= w_k_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TRANSPOSE_SEQ_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_blocks <= '0;
      perf_stall  <= '0;
    end else begin
      if (r_state == S_DRAIN && r_k == IDX_LAST) begin
        perf_blocks <= perf_blocks + 32'd1;
      end
      if (r_state == S_IDLE && r_in_cnt == CNT_FULL && r_out_cnt != '0) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_transpose_seq_ctrl.sv
// Bench for transpose_seq_ctrl: shift-register array model plus a scoreboard of expected transposed rows.
// Perf counter checks are compiled in with TRANSPOSE_SEQ_CTRL_PERF_CNT_EN.
module tb_transpose_seq_ctrl;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int VW = N * DW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          cfg_dir;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          busy;
  logic          arr_mode;
  logic          arr_dir;
  logic [VW-1:0] arr_in;
  logic [VW-1:0] arr_out;
`ifdef TRANSPOSE_SEQ_CTRL_PERF_CNT_EN
  logic [31:0]   perf_blocks;
  logic [31:0]   perf_stall;
`endif

  transpose_seq_ctrl #(.DATA_WIDTH(DW), .SYSTOLIC_WIDTH(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_dir   (cfg_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .arr_mode  (arr_mode),
    .arr_dir   (arr_dir),
    .arr_in    (arr_in),
    .arr_out   (arr_out)
`ifdef TRANSPOSE_SEQ_CTRL_PERF_CNT_EN
    ,
    .perf_blocks (perf_blocks),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [VW-1:0] sb_q [$];
  int            rdy_mode = 0;
  int            busy_run = 0;
  int            stall_cnt = 0;
  logic          exp_dir = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Array model: load shifts each row left taking arr_in lane r at the right; drain shifts rows vertically.
  logic [DW-1:0] a [N][N];
  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!arr_mode) begin
          if (c == N - 1) a[r][c] <= arr_in[r*DW +: DW];
          else            a[r][c] <= a[r][c+1];
        end else if (!arr_dir) begin
          if (r == N - 1) a[r][c] <= '0;
          else            a[r][c] <= a[r+1][c];
        end else begin
          if (r == 0)     a[r][c] <= '0;
          else            a[r][c] <= a[r-1][c];
        end
      end
    end
  end

  always_comb begin
    arr_out = '0;
    for (int c = 0; c < N; c++) begin
      arr_out[(N-1-c)*DW +: DW] = a[arr_dir ? N-1 : 0][c];
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("out_unexpected", 1, 0);
        else                  chk("out_data", out_data, sb_q.pop_front());
      end
      if (busy) begin
        chk("arr_mode_seq", arr_mode, (busy_run >= N) ? 1 : 0);
        chk("arr_dir_hold", arr_dir, exp_dir);
        if (busy_run >= N) chk("arr_in_drain", arr_in, 0);
        busy_run++;
      end else if (busy_run != 0) begin
        chk("busy_len", busy_run, 2 * N);
        busy_run = 0;
      end
      if (!busy && !in_ready && out_valid) stall_cnt++;
    end
  end

  function automatic logic [VW-1:0] mk_vec(input int base, input int k);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + 16 * k + i);
    return v;
  endfunction

  task automatic send_block(input int base, input logic dir, input bit gaps);
    logic [VW-1:0] e;
    bit            acc;
    int            t;
    exp_dir = dir;
    cfg_dir = dir;
    for (int k = 0; k < N; k++) begin
      for (int m = 0; m < N; m++) e[m*DW +: DW] = DW'(base + 16 * m + (dir ? (N - 1 - k) : k));
      sb_q.push_back(e);
    end
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = mk_vec(base, k);
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) chk("in_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!(sb_q.size() == 0 && !busy && !out_valid) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) chk(tag, 0, 1);
  endtask

  task automatic chk_rst();
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_arr_mode",  arr_mode,  0);
    chk("rst_arr_dir",   arr_dir,   0);
    chk("rst_arr_in",    arr_in,    0);
`ifdef TRANSPOSE_SEQ_CTRL_PERF_CNT_EN
    chk("rst_perf_blocks", perf_blocks, 0);
    chk("rst_perf_stall",  perf_stall,  0);
`endif
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    stall_cnt = 0;
    chk_rst();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cfg_dir  = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Top-first drain with a free-running consumer
    rdy_mode = 1;
    send_block(0, 1'b0, 1'b0);
    wait_done("s1_timeout");

    // Bottom-first drain
    send_block(0, 1'b1, 1'b0);
    wait_done("s2_timeout");

    // Random input gaps and output stalls
    rdy_mode = 2;
    send_block(0, 1'b0, 1'b1);
    send_block(16'h0040, 1'b0, 1'b1);
    wait_done("s3_timeout");
    rdy_mode = 1;

    // Reset in the middle of a drain, then a fresh block
    send_block(16'h0080, 1'b1, 1'b0);
    t = 0;
    while (busy_run != N + 2 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 100) chk("s5_drain_timeout", 0, 1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk_rst();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_block(16'h0200, 1'b0, 1'b0);
    wait_done("s5_timeout");

    // Back-to-back blocks with the consumer stalled
    do_reset();
    rdy_mode = 0;
    send_block(16'h0300, 1'b0, 1'b0);
    send_block(16'h0100, 1'b0, 1'b0);
    chk("s4_in_ready_full", in_ready, 0);
    repeat (10) begin
      @(negedge clk);
      chk("s4_load_held", busy, 0);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    wait_done("s4_timeout");
    chk("s4_stall_seen", (stall_cnt >= 10) ? 1 : 0, 1);
`ifdef TRANSPOSE_SEQ_CTRL_PERF_CNT_EN
    chk("perf_blocks", perf_blocks, 2);
    chk("perf_stall",  perf_stall,  stall_cnt);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
